// File: rtl/cam_power_seq_if.sv
// Control/status bundle between software-side control and the camera power sequencer.
// The master drives the requests; the slave (sequencer) drives pins and status.
interface cam_power_seq_if;
  logic       cfg_enable;
  logic       wdog_en;
  logic       frame_done;
  logic       cnt_clr;
  logic       cam_pwdn;
  logic       cam_rstn;
  logic       rx_enable;
  logic       busy;
  logic [2:0] state_o;
  logic [7:0] restart_cnt;

  modport master (
    output cfg_enable, wdog_en, frame_done, cnt_clr,
    input  cam_pwdn, cam_rstn, rx_enable, busy, state_o, restart_cnt
  );

  modport slave (
    input  cfg_enable, wdog_en, frame_done, cnt_clr,
    output cam_pwdn, cam_rstn, rx_enable, busy, state_o, restart_cnt
  );
endinterface

// File: rtl/cam_power_seq.sv
// Camera power/reset sequencer with drain-on-stop and frame watchdog.
// One shared down-counter times every phase, the OFF dwell and the RUN watchdog.
module cam_power_seq #(
  parameter int CNT_W        = 24,
  parameter int T_PWUP_CYC   = 1000,
  parameter int T_SETTLE_CYC = 20000,
  parameter int T_RST_CYC    = 500,
  parameter int T_STOP_CYC   = 100000,
  parameter int WDOG_CYC     = 2000000
) (
  input logic            clk,
  input logic            rst,
  cam_power_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWUP   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_PWDN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LD_PWUP   = CNT_W'(T_PWUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STOP   = CNT_W'(T_STOP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WDOG   = CNT_W'(WDOG_CYC - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pins;   // {pwdn, rstn, rx_en, busy}
  logic [7:0]       rcnt;
  logic             cnt_zero;
  logic             trip;

  // Pin pattern for the state being entered, so outputs stay registered.
  function automatic logic [3:0] pins_of(input state_t s);
    case (s)
      S_OFF:    return 4'b1000;
      S_PWUP:   return 4'b0001;
      S_SETTLE: return 4'b0101;
      S_RUN:    return 4'b0110;
      S_DRAIN:  return 4'b0111;
      S_PWDN:   return 4'b0001;
      default:  return 4'b1000;
    endcase
  endfunction

  assign cnt_zero = (cnt == '0);
  // A stop request or a frame in the same cycle both pre-empt a watchdog trip.
  assign trip = (state == S_RUN) && bus.cfg_enable && bus.wdog_en &&
                !bus.frame_done && cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      cnt   <= '0;
      pins  <= pins_of(S_OFF);
      rcnt  <= '0;
    end else begin
      if (bus.cnt_clr)                rcnt <= '0;
      else if (trip && rcnt != 8'hFF) rcnt <= rcnt + 8'd1;

      case (state)
        S_OFF: begin
          if (bus.cfg_enable && cnt_zero) begin
            state <= S_PWUP; pins <= pins_of(S_PWUP); cnt <= LD_PWUP;
          end else if (!cnt_zero) cnt <= cnt - ONE;
        end
        S_PWUP: begin
          if (!bus.cfg_enable) begin
            state <= S_PWDN; pins <= pins_of(S_PWDN); cnt <= LD_RST;
          end else if (cnt_zero) begin
            state <= S_SETTLE; pins <= pins_of(S_SETTLE); cnt <= LD_SETTLE;
          end else cnt <= cnt - ONE;
        end
        S_SETTLE: begin
          if (!bus.cfg_enable) begin
            state <= S_PWDN; pins <= pins_of(S_PWDN); cnt <= LD_RST;
          end else if (cnt_zero) begin
            state <= S_RUN; pins <= pins_of(S_RUN); cnt <= LD_WDOG;
          end else cnt <= cnt - ONE;
        end
        S_RUN: begin
          if (!bus.cfg_enable) begin
            state <= S_DRAIN; pins <= pins_of(S_DRAIN); cnt <= LD_STOP;
          end else if (bus.frame_done || !bus.wdog_en) begin
            cnt <= LD_WDOG;
          end else if (cnt_zero) begin
            state <= S_PWDN; pins <= pins_of(S_PWDN); cnt <= LD_RST;
          end else cnt <= cnt - ONE;
        end
        S_DRAIN: begin
          if (bus.frame_done || cnt_zero) begin
            state <= S_PWDN; pins <= pins_of(S_PWDN); cnt <= LD_RST;
          end else cnt <= cnt - ONE;
        end
        S_PWDN: begin
          // Reload doubles as the minimum OFF dwell before the next power-up.
          if (cnt_zero) begin
            state <= S_OFF; pins <= pins_of(S_OFF); cnt <= LD_RST;
          end else cnt <= cnt - ONE;
        end
        default: begin
          state <= S_PWDN; pins <= pins_of(S_PWDN); cnt <= LD_RST;
        end
      endcase
    end
  end

  assign bus.cam_pwdn    = pins[3];
  assign bus.cam_rstn    = pins[2];
  assign bus.rx_enable   = pins[1];
  assign bus.busy        = pins[0];
  assign bus.state_o     = state;
  assign bus.restart_cnt = rcnt;
endmodule

// File: tb/tb_cam_power_seq.sv
// Directed + randomized bench for cam_power_seq against a cycle-level phase model.
// Model tracks time-in-state and cycles-since-last-frame rather than a down-counter.
module tb_cam_power_seq;
  localparam int TPW = 4, TSE = 8, TRS = 3, TST = 16, TWD = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cam_power_seq_if bus();

  cam_power_seq #(
    .CNT_W(24), .T_PWUP_CYC(TPW), .T_SETTLE_CYC(TSE),
    .T_RST_CYC(TRS), .T_STOP_CYC(TST), .WDOG_CYC(TWD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 OFF,1 PWUP,2 SETTLE,3 RUN,4 DRAIN,5 PWDN
  int m_st, m_age, m_wd, m_dwell, m_rc;
  logic [3:0] pins_tbl [0:5] = '{4'b1000, 4'b0001, 4'b0101, 4'b0110, 4'b0111, 4'b0001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_wd = 0; m_dwell = 0; m_rc = 0;
  endtask

  task automatic model_step(input bit cfg, input bit wden, input bit fd, input bit clr);
    int  nx;
    bit  tripped;
    nx = m_st;
    tripped = 0;
    case (m_st)
      0: if (cfg && (m_age + 1 >= m_dwell)) nx = 1;
      1: if (!cfg) nx = 5; else if (m_age + 1 == TPW) nx = 2;
      2: if (!cfg) nx = 5; else if (m_age + 1 == TSE) nx = 3;
      3: begin
        if (!cfg) nx = 4;
        else if (fd || !wden) m_wd = 0;
        else if (m_wd == TWD - 1) begin tripped = 1; nx = 5; end
        else m_wd++;
      end
      4: if (fd || (m_age + 1 == TST)) nx = 5;
      5: if (m_age + 1 == TRS) begin nx = 0; m_dwell = TRS; end
      default: nx = 5;
    endcase
    if (clr) m_rc = 0;
    else if (tripped && m_rc < 255) m_rc++;
    if (nx != m_st) begin m_age = 0; m_wd = 0; end
    else m_age++;
    m_st = nx;
  endtask

  task automatic check_all();
    chk("state", bus.state_o, m_st);
    chk("pins", {bus.cam_pwdn, bus.cam_rstn, bus.rx_enable, bus.busy}, pins_tbl[m_st]);
    chk("restart_cnt", bus.restart_cnt, m_rc);
  endtask

  task automatic cyc(input bit cfg, input bit wden, input bit fd, input bit clr);
    bus.cfg_enable = cfg;
    bus.wdog_en    = wden;
    bus.frame_done = fd;
    bus.cnt_clr    = clr;
    @(posedge clk);
    model_step(cfg, wden, fd, clr);
    #1;
    check_all();
  endtask

  task automatic run_until(input bit cfg, input bit wden, input int target, input int lim);
    int n;
    n = 0;
    while (int'(bus.state_o) != target && n < lim) begin
      cyc(cfg, wden, 1'b0, 1'b0);
      n++;
    end
    chk("reach_state", bus.state_o, target);
  endtask

  initial begin
    int n, trips;
    logic [2:0] prev;
    bit rcfg;

    bus.cfg_enable = 0; bus.wdog_en = 0; bus.frame_done = 0; bus.cnt_clr = 0;
    model_reset();
    #12;
    chk("rst_state", bus.state_o, 0);
    chk("rst_pins", {bus.cam_pwdn, bus.cam_rstn, bus.rx_enable, bus.busy}, 4'b1000);
    chk("rst_rcnt", bus.restart_cnt, 0);
    @(negedge clk);
    rst = 0;

    // Power-up timeline
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 1)  chk("pu_c1", bus.state_o, 1);
      if (i == 5)  chk("pu_c5", bus.state_o, 2);
      if (i == 13) chk("pu_c13", {bus.state_o, bus.rx_enable}, {3'd3, 1'b1});
    end

    // Drain ended by frame_done
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    run_until(0, 0, 0, 20);
    chk("drain_off_pwdn", bus.cam_pwdn, 1);

    // Drain timeout length
    run_until(1, 0, 3, 40);
    cyc(0, 0, 0, 0);
    n = 0;
    while (bus.state_o == 3'd4 && n < 40) begin n++; cyc(0, 0, 0, 0); end
    chk("drain_len", n, TST);
    chk("drain_to_pwdn", bus.state_o, 5);

    // Watchdog trip and auto re-power
    run_until(1, 1, 3, 60);
    n = 0;
    while (bus.state_o == 3'd3 && n < 60) begin n++; cyc(1, 1, 0, 0); end
    chk("wdog_len", n, TWD);
    chk("wdog_pwdn", bus.state_o, 5);
    chk("wdog_rcnt", bus.restart_cnt, 1);
    run_until(1, 1, 3, 60);
    for (int i = 1; i <= 100; i++) cyc(1, 1, (i % 20) == 0, 0);
    chk("wdog_fed_state", bus.state_o, 3);
    chk("wdog_fed_rcnt", bus.restart_cnt, 1);

    // Abort during SETTLE, re-request during PWDN
    run_until(0, 0, 0, 40);
    run_until(1, 0, 2, 20);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("abort_pwdn", {bus.state_o, bus.rx_enable}, {3'd5, 1'b0});
    while (bus.state_o == 3'd5 && n < 200) begin n++; cyc(1, 0, 0, 0); end
    n = 0;
    while (bus.state_o == 3'd0 && n < 20) begin n++; cyc(1, 0, 0, 0); end
    chk("off_dwell", n, TRS);
    chk("dwell_to_pwup", bus.state_o, 1);

    // Randomized traffic
    rcfg = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) rcfg = ~rcfg;
      cyc(rcfg, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 63) == 0);
    end

    // Saturation then clear
    cyc(1, 1, 0, 1);
    trips = 0; n = 0;
    while (trips < 260 && n < 20000) begin
      prev = bus.state_o;
      cyc(1, 1, 0, 0);
      if (prev == 3'd3 && bus.state_o == 3'd5) trips++;
      n++;
    end
    chk("trips", trips, 260);
    chk("sat_rcnt", bus.restart_cnt, 255);
    cyc(1, 1, 0, 1);
    chk("clr_rcnt", bus.restart_cnt, 0);

    // Async reset mid power-up
    run_until(0, 0, 0, 60);
    run_until(1, 0, 1, 10);
    cyc(1, 0, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_state", bus.state_o, 0);
    chk("arst_pins", {bus.cam_pwdn, bus.cam_rstn, bus.rx_enable, bus.busy}, 4'b1000);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    cyc(1, 0, 0, 0);
    chk("post_rst_pwup", bus.state_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
